// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Purpose
//   This block is the read-side companion to the register file. When started,
//   it walks addresses START_ADDR..NUM_REGS-1 through the combinational regfile
//   read port, one address at a time. It captures each word into a local
//   register and offers it on a valid/ready stream, where debug-dump or
//   checkpoint logic can consume it. The core owns the regfile read-address
//   mux and gives this block rd_addr_o only while busy_o is high.
//
// Ports
//   clk          clock, rising edge
//   clr          asynchronous, active-high reset
//   start_i      begin a dump (sampled only in IDLE)
//   abort_i      cancel the dump in progress (synchronous; beaten only by clr)
//   busy_o       high in FETCH and PRESENT
//   done_o       one-cycle pulse after the last word is accepted
//   rd_addr_o    regfile read address (meaningful while busy_o)
//   rd_data_i    regfile read data, combinational from rd_addr_o
//   out_valid_o  presented word available
//   out_ready_i  consumer ready
//   out_addr_o   address of the presented word
//   out_data_o   captured data of the presented word
//   out_last_o   presented word is address NUM_REGS-1
//   state_o      current FSM state (debug visibility)
//
// Handshake
//   A word transfers on a rising edge where out_valid_o and out_ready_i are
//   both high. Once out_valid_o is raised, it stays high and out_addr_o,
//   out_data_o and out_last_o hold stable until that transfer happens. The
//   only other ways out of this are abort_i and clr. out_valid_o never depends
//   combinationally on out_ready_i.
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
   parameter int NUM_REGS   = 32,
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int START_ADDR = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_last_o,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_PRESENT = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

   state_t              state_q,     state_d;
   logic [ADDR_W-1:0]   addr_q,      addr_d;      // walk counter, drives rd_addr_o
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q,  out_last_d;
   logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
   logic [DATA_W-1:0]   out_data_q,  out_data_d;

   // ---------------------------------------------------------------------------
   // Next-state logic. Every output is registered, so each transition below
   // also sets the output values that belong to the state being entered.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      busy_d      = busy_q;
      done_d      = done_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;

      case (state_q)
         S_IDLE: begin
            // When start and abort arrive together, abort wins and we stay idle.
            if (start_i && !abort_i) begin
               state_d = S_FETCH;
               addr_d  = FIRST_ADDR;
               busy_d  = 1'b1;
            end
         end

         S_FETCH: begin
            if (abort_i) begin
               state_d     = S_IDLE;
               addr_d      = '0;
               busy_d      = 1'b0;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end else begin
               // Capture point: the presented word is the regfile content at the
               // end of this cycle. Later regfile writes cannot reach it.
               state_d     = S_PRESENT;
               out_data_d  = rd_data_i;
               out_addr_d  = addr_q;
               out_last_d  = (addr_q == LAST_ADDR);
               out_valid_d = 1'b1;
            end
         end

         S_PRESENT: begin
            if (abort_i) begin
               // A handshake in this same cycle has already completed on the
               // consumer side. We simply stop walking.
               state_d     = S_IDLE;
               addr_d      = '0;
               busy_d      = 1'b0;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end else if (out_ready_i) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (addr_q == LAST_ADDR) begin
                  // The counter stops at LAST_ADDR, so no out-of-range address
                  // is ever driven.
                  state_d = S_DONE;
                  addr_d  = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  addr_d  = addr_q + 1'b1;
               end
            end
         end

         S_DONE: begin
            // This state always lasts one cycle. Abort here still ends in IDLE.
            state_d = S_IDLE;
            done_d  = 1'b0;
         end

         default: begin
            state_d     = S_IDLE;
            addr_d      = '0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign rd_addr_o   = addr_q;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign out_addr_o  = out_addr_q;
   assign out_data_o  = out_data_q;
   assign state_o     = state_q;

endmodule
